// File: rtl/wallace_pkg.sv
// wallace_pkg: reduction-tree sizing and register-placement helpers for wallace_mult_pipe
package wallace_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int PW = 2 * DEF_WIDTH;
  // Rows entering 3:2 level `level`: WIDTH partial-product rows plus one Baugh-Wooley constant row
  function automatic int height(input int level, input int width);
    int h = width + 1;
    for (int i = 0; i < level; i++) if (h > 2) h = 2 * (h / 3) + h % 3;
    return h;
  endfunction
  function automatic int csa_levels(input int width);
    int n = 0;
    for (int i = 0; i < 64; i++) if (height(i, width) > 2) n++;
    return n;
  endfunction
  // Steps 0..L-1 are CSA levels, step L is the final adder; ranks spread evenly over them
  function automatic int stage_of_level(input int level, input int pipe_stages, input int width);
    return (level * pipe_stages) / (csa_levels(width) + 1);
  endfunction
endpackage

// File: rtl/wallace_csa_row.sv
// wallace_csa_row: N-bit 3:2 compressor row, carry pre-shifted into the next column
module wallace_csa_row #(
  parameter int N = 16
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [N-1:0] i_c,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);
  assign sum = i_a ^ i_b ^ i_c;
  assign carry = ((i_a & i_b) | (i_a & i_c) | (i_b & i_c)) << 1;
endmodule

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: pipelined signed/unsigned Wallace-tree multiplier on valid/ready streams
module wallace_mult_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PIPE_STAGES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P
);
  localparam int PWID = 2 * WIDTH;
  localparam int L = csa_levels(WIDTH);
  logic w_en;
  logic [PIPE_STAGES-1:0] r_v, w_vin;
  logic [WIDTH:0][PWID-1:0] w_pp;
  assign w_en = ~r_v[PIPE_STAGES-1] | out_ready;
  assign in_ready = w_en;
  assign out_valid = r_v[PIPE_STAGES-1];
  always_comb begin
    w_vin = '0;
    w_vin[0] = in_valid;
    for (int k = 1; k < PIPE_STAGES; k++) w_vin[k] = r_v[k-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_v <= '0;
    else if (w_en) r_v <= w_vin;
  // Baugh-Wooley: cross terms with exactly one operand MSB are inverted in signed mode
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        w_pp[i][i+j] = (A[j] & B[i]) ^ (is_signed & ((i == WIDTH - 1) ^ (j == WIDTH - 1)));
    w_pp[WIDTH][WIDTH] = is_signed;
    w_pp[WIDTH][PWID-1] = is_signed;
  end
  for (genvar l = 0; l <= L; l++) begin : g_st
    localparam int HI = height(l, WIDTH);
    localparam int HO = (l == L) ? 1 : height(l + 1, WIDTH);
    localparam int R0 = stage_of_level(l, PIPE_STAGES, WIDTH);
    localparam int NR = ((l == L) ? PIPE_STAGES : stage_of_level(l + 1, PIPE_STAGES, WIDTH)) - R0;
    logic [HI-1:0][PWID-1:0] w_src;
    logic [HO-1:0][PWID-1:0] w_out, w_res;
    if (l == 0) begin : g_src0
      assign w_src = w_pp;
    end else begin : g_srcn
      assign w_src = g_st[l-1].w_res;
    end
    if (l < L) begin : g_csa
      localparam int G = HI / 3;
      for (genvar k = 0; k < G; k++) begin : g_row
        wallace_csa_row #(.N(PWID)) u_row (
          .i_a(w_src[3*k]), .i_b(w_src[3*k+1]), .i_c(w_src[3*k+2]),
          .sum(w_out[2*k]), .carry(w_out[2*k+1])
        );
      end
      for (genvar k = 0; k < HI % 3; k++) begin : g_pass
        assign w_out[2*G+k] = w_src[3*G+k];
      end
    end else begin : g_cpa
      assign w_out[0] = w_src[0] + w_src[1];
    end
    // Ranks load only on a valid beat so P keeps its last product across bubbles
    if (NR > 0) begin : g_reg
      logic [HO-1:0][PWID-1:0] r_q [NR];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_q <= '{default: '0};
        else if (w_en) begin
          if (w_vin[R0]) r_q[0] <= w_out;
          for (int m = 1; m < NR; m++) if (w_vin[R0+m]) r_q[m] <= r_q[m-1];
        end
      assign w_res = r_q[NR-1];
    end else begin : g_wire
      assign w_res = w_out;
    end
  end
  assign P = g_st[L].w_res[0];
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe: directed and exhaustive checks of wallace_mult_pipe against an arithmetic model
module tb_wallace_mult_pipe;
  localparam int W = 8;
  localparam int PS = 3;
  typedef struct {logic [63:0] val; int push; int sc;} ent_t;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, is_signed = 0, out_valid, out_ready = 1;
  logic [W-1:0] a = '0, b = '0;
  logic [2*W-1:0] p;
  logic v5 = 0, s5 = 0, rdy5, ov5;
  logic [4:0] a5 = '0, b5 = '0;
  logic [9:0] p5;
  int total = 0, passed = 0, cyc = 0, c5 = 0, stalls = 0;
  logic due, due5;
  ent_t q[$], q5[$];

  always #5 clk = ~clk;

  wallace_mult_pipe #(.WIDTH(W), .PIPE_STAGES(PS)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .is_signed(is_signed), .out_valid(out_valid), .out_ready(out_ready), .P(p)
  );
  wallace_mult_pipe #(.WIDTH(5), .PIPE_STAGES(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(rdy5), .A(a5), .B(b5),
    .is_signed(s5), .out_valid(ov5), .out_ready(1'b1), .P(p5)
  );

  function automatic logic [63:0] model(input longint x, input longint y, input bit s, input int w);
    longint sx = (s && x[w-1]) ? x - (longint'(1) << w) : x;
    longint sy = (s && y[w-1]) ? y - (longint'(1) << w) : y;
    return 64'((sx * sy) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", n, act, exp);
  endtask

  // Items emerge PS cycles after acceptance, delayed by one cycle per stall seen since
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_p", 64'(p), 64'd0);
    end else begin
      due = q.size() > 0 && q[0].push + PS + stalls - q[0].sc <= cyc;
      chk("out_valid", 64'(out_valid), 64'(due));
      chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid && q.size() > 0) chk("p", 64'(p), q[0].val);
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (out_valid && !out_ready) stalls++;
      if (in_valid && in_ready) q.push_back('{model(longint'(a), longint'(b), is_signed, W), cyc, stalls});
    end
  end

  always @(negedge clk) begin
    c5++;
    if (!rst_n) q5.delete();
    else begin
      due5 = q5.size() > 0 && q5[0].push + 4 <= c5;
      chk("w5_out_valid", 64'(ov5), 64'(due5));
      if (ov5 && q5.size() > 0) begin
        chk("w5_p", 64'(p5), q5[0].val);
        void'(q5.pop_front());
      end
      if (v5) begin
        chk("w5_in_ready", 64'(rdy5), 64'd1);
        q5.push_back('{model(longint'(a5), longint'(b5), s5, 5), c5, 0});
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic ok = 0;
    a = x;
    b = y;
    is_signed = s;
    in_valid = 1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic lit(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic [2*W-1:0] e);
    send(x, y, s);
    @(negedge clk);
    @(negedge clk);
    chk("lat_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lit_p", 64'(p), 64'(e));
    @(negedge clk);
    chk("one_beat", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("idle_p", 64'(p), 64'd0);
    @(posedge clk);
    #1;
    lit(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    lit(8'h80, 8'h80, 1'b1, 16'h4000);
    lit(8'hFF, 8'h01, 1'b1, 16'hFFFF);
    lit(8'h7F, 8'h80, 1'b1, 16'hC080);
    lit(8'h80, 8'h80, 1'b0, 16'h4000);
    lit(8'hFF, 8'hFF, 1'b1, 16'h0001);
    lit(8'h0C, 8'hF6, 1'b1, 16'hFF88);
    lit(8'h0C, 8'hF6, 1'b0, 16'h0B88);
    for (int i = 0; i < 10; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
    idle(6);
    chk("b2b_drained", 64'(q.size()), 64'd0);
    fork
      begin
        for (int i = 0; i < 6; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    idle(10);
    chk("bp_drained", 64'(q.size()), 64'd0);
    for (int i = 0; i < 3; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    idle(8);
    chk("no_stale_valid", 64'(out_valid), 64'd0);
    chk("no_stale_p", 64'(p), 64'd0);
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 32; x++)
        for (int y = 0; y < 32; y++) begin
          a5 = 5'(x);
          b5 = 5'(y);
          s5 = 1'(s);
          v5 = 1;
          @(posedge clk);
          #1;
        end
    v5 = 0;
    idle(8);
    chk("w5_drained", 64'(q5.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
